// File: rtl/cdma_spread_sched.sv
// Round-robin frame scheduler feeding a shared Gold-code spreader (set/seed/signal).
// Optional build macro CDMA_PREAMBLE_EN prepends a one-bit all-ones preamble to every frame.
module cdma_spread_sched #(
  parameter int unsigned NUM_USERS      = 4,
  parameter int unsigned CHIPS_PER_BIT  = 31,
  parameter int unsigned BITS_PER_FRAME = 8,
  parameter int unsigned GUARD_CYCLES   = 2
) (
  input  logic                   clk_i,
  input  logic                   set_i,
  input  logic [NUM_USERS-1:0]   req_i,
  input  logic [5*NUM_USERS-1:0] seed_table_i,
  input  logic [NUM_USERS-1:0]   data_i,
  output logic [NUM_USERS-1:0]   grant_o,
  output logic                   bit_ack_o,
  output logic                   frame_done_o,
  output logic                   abort_o,
  output logic                   seed_err_o,
  output logic                   spr_set_no,
  output logic [4:0]             spr_seed_o,
  output logic                   spr_signal_o
);

`ifdef CDMA_PREAMBLE_EN
  localparam int unsigned NumBits  = BITS_PER_FRAME + 1;
  localparam logic        Preamble = 1'b1;
`else
  localparam int unsigned NumBits  = BITS_PER_FRAME;
  localparam logic        Preamble = 1'b0;
`endif

  localparam int unsigned PtrW   = $clog2(NUM_USERS);
  localparam int unsigned ChipW  = $clog2(CHIPS_PER_BIT);
  localparam int unsigned BitW   = $clog2(NumBits + 1);
  localparam int unsigned GuardW = $clog2(GUARD_CYCLES + 1);

  localparam logic [ChipW-1:0]  ChipLast   = ChipW'(CHIPS_PER_BIT - 1);
  localparam logic [ChipW-1:0]  ChipPenult = ChipW'(CHIPS_PER_BIT - 2);
  localparam logic [BitW-1:0]   BitLast    = BitW'(NumBits - 1);
  localparam logic [GuardW-1:0] GuardLast  = GuardW'(GUARD_CYCLES - 1);
  localparam logic [PtrW-1:0]   PtrLast    = PtrW'(NUM_USERS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSpread, StGuard} state_e;

  state_e                state_q, state_d;
  logic [NUM_USERS-1:0]  grant_q, grant_d;
  logic                  bit_ack_q, bit_ack_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
  logic                  set_n_q, set_n_d;
  logic [4:0]            seed_q, seed_d;
  logic                  signal_q, signal_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [ChipW-1:0]      chip_q, chip_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [GuardW-1:0]     guard_q, guard_d;

  logic [NUM_USERS-1:0]  elig, zero_req;
  logic                  found;
  logic [PtrW-1:0]       win_idx;
  int unsigned           cand;
  logic                  req_g, data_g, last_chip, last_bit;

  for (genvar u = 0; u < NUM_USERS; u++) begin : g_elig
    assign elig[u]     = req_i[u] && (seed_table_i[5*u +: 5] != 5'd0);
    assign zero_req[u] = req_i[u] && (seed_table_i[5*u +: 5] == 5'd0);
  end

  // First eligible user at or above the pointer, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NUM_USERS; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_USERS) cand = cand - NUM_USERS;
      if (!found && elig[PtrW'(cand)]) begin
        found   = 1'b1;
        win_idx = PtrW'(cand);
      end
    end
  end

  assign req_g     = |(req_i & grant_q);
  assign data_g    = |(data_i & grant_q);
  assign last_chip = (chip_q == ChipLast);
  assign last_bit  = (bit_q == BitLast);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    bit_ack_d = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    err_d     = err_q;
    set_n_d   = set_n_q;
    seed_d    = seed_q;
    signal_d  = signal_q;
    ptr_d     = ptr_q;
    chip_d    = chip_q;
    bit_d     = bit_q;
    guard_d   = guard_q;
    unique case (state_q)
      StIdle: begin
        set_n_d = 1'b0;
        if (|zero_req) err_d = 1'b1;
        if (found) begin
          state_d          = StLoad;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          seed_d           = seed_table_i[5*win_idx +: 5];
          ptr_d            = (win_idx == PtrLast) ? '0 : win_idx + 1'b1;
        end
      end
      StLoad: begin
        if (!req_g) begin
          state_d  = StGuard;
          abort_d  = 1'b1;
          grant_d  = '0;
          set_n_d  = 1'b0;
          signal_d = 1'b0;
          guard_d  = '0;
        end else begin
          state_d   = StSpread;
          set_n_d   = 1'b1;
          chip_d    = '0;
          bit_d     = '0;
          signal_d  = Preamble ? 1'b1 : data_g;
          bit_ack_d = !Preamble;
        end
      end
      StSpread: begin
        // Completion wins over a request drop on the very last chip (frame_done already shown).
        if (last_chip && last_bit) begin
          state_d  = StGuard;
          grant_d  = '0;
          set_n_d  = 1'b0;
          signal_d = 1'b0;
          guard_d  = '0;
        end else if (!req_g) begin
          state_d  = StGuard;
          abort_d  = 1'b1;
          grant_d  = '0;
          set_n_d  = 1'b0;
          signal_d = 1'b0;
          guard_d  = '0;
        end else if (last_chip) begin
          chip_d    = '0;
          bit_d     = bit_q + 1'b1;
          signal_d  = data_g;
          bit_ack_d = 1'b1;
        end else begin
          chip_d = chip_q + 1'b1;
          done_d = last_bit && (chip_q == ChipPenult);
        end
      end
      StGuard: begin
        if (guard_q == GuardLast) state_d = StIdle;
        else guard_d = guard_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge set_i) begin
    if (!set_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      bit_ack_q <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      set_n_q   <= 1'b0;
      seed_q    <= 5'b00001;
      signal_q  <= 1'b0;
      ptr_q     <= '0;
      chip_q    <= '0;
      bit_q     <= '0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      bit_ack_q <= bit_ack_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      set_n_q   <= set_n_d;
      seed_q    <= seed_d;
      signal_q  <= signal_d;
      ptr_q     <= ptr_d;
      chip_q    <= chip_d;
      bit_q     <= bit_d;
      guard_q   <= guard_d;
    end
  end

  assign grant_o      = grant_q;
  assign bit_ack_o    = bit_ack_q;
  assign frame_done_o = done_q;
  assign abort_o      = abort_q;
  assign seed_err_o   = err_q;
  assign spr_set_no   = set_n_q;
  assign spr_seed_o   = seed_q;
  assign spr_signal_o = signal_q;

endmodule

// File: tb/tb_cdma_spread_sched.sv
// Self-checking bench for cdma_spread_sched: arbitration table, abort/reset sequences,
// and randomized frames against a frame-level reference model.
module tb_cdma_spread_sched;
  localparam int NU  = 4;
  localparam int CPB = 31;
  localparam int BPF = 8;
`ifdef CDMA_PREAMBLE_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic          clk_i = 1'b0;
  logic          set_i;
  logic [NU-1:0] req_i;
  logic [5*NU-1:0] seed_table_i;
  logic [NU-1:0] data_i;
  logic [NU-1:0] grant_o;
  logic          bit_ack_o, frame_done_o, abort_o, seed_err_o, spr_set_no, spr_signal_o;
  logic [4:0]    spr_seed_o;

  cdma_spread_sched dut (
    .clk_i       (clk_i),
    .set_i       (set_i),
    .req_i       (req_i),
    .seed_table_i(seed_table_i),
    .data_i      (data_i),
    .grant_o     (grant_o),
    .bit_ack_o   (bit_ack_o),
    .frame_done_o(frame_done_o),
    .abort_o     (abort_o),
    .seed_err_o  (seed_err_o),
    .spr_set_no  (spr_set_no),
    .spr_seed_o  (spr_seed_o),
    .spr_signal_o(spr_signal_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr  = 0;
  logic m_err = 1'b0;

  localparam logic [14:0] ResetVec = 15'h0002;

  typedef struct {
    logic [NU-1:0]   req;
    logic [5*NU-1:0] seeds;
    logic [BPF-1:0]  bits;
    int              win;
    logic            err;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [14:0] pack_out();
    return {grant_o, bit_ack_o, frame_done_o, abort_o, seed_err_o, spr_set_no, spr_seed_o,
            spr_signal_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Frame-level arbitration model: round-robin over users with req and a nonzero seed.
  task automatic model_pick(input logic [NU-1:0] req, input logic [5*NU-1:0] seeds,
                            output int win);
    int u;
    win = -1;
    for (int k = 0; k < NU; k++)
      if (req[k] && seeds[5*k +: 5] == 5'd0) m_err = 1'b1;
    for (int i = 0; i < NU; i++) begin
      u = (m_ptr + i) % NU;
      if (win < 0 && req[u] && seeds[5*u +: 5] != 5'd0) win = u;
    end
    if (win >= 0) m_ptr = (win + 1) % NU;
  endtask

  task automatic run_frame(input logic [NU-1:0] req, input logic [5*NU-1:0] seeds,
                           input logic [BPF-1:0] bits, input int exp_win, input logic exp_err,
                           input int abort_at);
    logic [NU-1:0] g;
    logic [4:0]    exp_seed;
    int   j, b, len;
    logic exp_sig, exp_ack, aborted;
    g = '0;
    g[exp_win] = 1'b1;
    exp_seed = seeds[5*exp_win +: 5];
    j = 0;
    aborted = 1'b0;
    len = (BPF + PRE) * CPB;
    req_i = req;
    seed_table_i = seeds;
    data_i = NU'($urandom);
    data_i[exp_win] = bits[0];
    step();
    check("load_grant", grant_o, g);
    check("load_seed", spr_seed_o, exp_seed);
    check("load_set_n", spr_set_no, 1'b0);
    check("load_ack", bit_ack_o, 1'b0);
    check("load_seed_err", seed_err_o, exp_err);
    req_i = NU'($urandom);
    req_i[exp_win] = 1'b1;
    data_i = NU'($urandom);
    data_i[exp_win] = bits[0];
    for (int s = 1; s <= len; s++) begin
      step();
      b = (s - 1) / CPB;
      exp_sig = (b < PRE) ? 1'b1 : bits[b-PRE];
      exp_ack = ((s - 1) % CPB == 0) && (b >= PRE);
      check("spr_grant", grant_o, g);
      check("spr_set_n", spr_set_no, 1'b1);
      check("spr_seed", spr_seed_o, exp_seed);
      check("spr_signal", spr_signal_o, exp_sig);
      check("spr_bit_ack", bit_ack_o, exp_ack);
      check("spr_frame_done", frame_done_o, s == len);
      check("spr_abort", abort_o, 1'b0);
      if (exp_ack) j++;
      if (s == abort_at) begin
        req_i = '0;
        step();
        check("abort_pulse", abort_o, 1'b1);
        check("abort_grant", grant_o, '0);
        check("abort_set_n", spr_set_no, 1'b0);
        check("abort_signal", spr_signal_o, 1'b0);
        check("abort_no_done", frame_done_o, 1'b0);
        check("abort_no_ack", bit_ack_o, 1'b0);
        aborted = 1'b1;
        break;
      end
      req_i = NU'($urandom);
      req_i[exp_win] = 1'b1;
      seed_table_i = (5*NU)'($urandom);
      data_i = NU'($urandom);
      data_i[exp_win] = (j < BPF) ? bits[j] : 1'b0;
    end
    req_i = '0;
    for (int k = 0; k < (aborted ? 2 : 3); k++) begin
      step();
      check("guard_grant", grant_o, '0);
      check("guard_set_n", spr_set_no, 1'b0);
      check("guard_signal", spr_signal_o, 1'b0);
      check("guard_pulses", {bit_ack_o, frame_done_o, abort_o}, 3'b000);
    end
  endtask

  initial begin
    int win;
    logic [NU-1:0]   r;
    logic [5*NU-1:0] sd;
    logic [4:0]      sv;
    logic            any;

    tbl[0] = '{4'b0001, {5'h00, 5'h00, 5'h00, 5'b10101}, 8'h4D, 0, 1'b0};
    tbl[1] = '{4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, 8'hA5, 1, 1'b0};
    tbl[2] = '{4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, 8'h3C, 2, 1'b0};
    tbl[3] = '{4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, 8'hFF, 3, 1'b0};
    tbl[4] = '{4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, 8'h01, 0, 1'b0};
    tbl[5] = '{4'b0110, {5'h05, 5'h09, 5'h00, 5'h11}, 8'h96, 2, 1'b1};
    tbl[6] = '{4'b0011, {5'h05, 5'h09, 5'h13, 5'h11}, 8'h80, 0, 1'b1};

    set_i = 1'b0;
    req_i = '0;
    seed_table_i = '0;
    data_i = '0;
    step();
    step();
    check("reset_outputs", pack_out(), ResetVec);
    set_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      check("idle_no_req", pack_out(), ResetVec);
    end

    for (int i = 0; i < 7; i++) begin
      model_pick(tbl[i].req, tbl[i].seeds, win);
      run_frame(tbl[i].req, tbl[i].seeds, tbl[i].bits, tbl[i].win, tbl[i].err, -1);
    end
    check("seed_err_sticky", seed_err_o, 1'b1);

    // Granted user drops its request at overall chip 40.
    model_pick(4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, win);
    run_frame(4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, 8'h5A, win, m_err, 41);
    check("abort_win_expected", win, 1);

    // Asynchronous reset in the middle of a frame.
    req_i = 4'b1111;
    seed_table_i = {5'h1C, 5'h0B, 5'h07, 5'h12};
    data_i = 4'b1111;
    step();
    check("pre_reset_load", grant_o, 4'b0100);
    for (int c = 0; c < 20; c++) step();
    #3;
    set_i = 1'b0;
    #1;
    check("midframe_reset", pack_out(), ResetVec);
    req_i = '0;
    step();
    check("midframe_reset_hold", pack_out(), ResetVec);
    set_i = 1'b1;
    m_ptr = 0;
    m_err = 1'b0;
    model_pick(4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, win);
    run_frame(4'b1111, {5'h1C, 5'h0B, 5'h07, 5'h12}, 8'hC3, win, m_err, -1);

    for (int n = 0; n < 10; n++) begin
      do begin
        r = NU'($urandom);
        any = 1'b0;
        for (int u = 0; u < NU; u++) begin
          sv = 5'($urandom_range(1, 31));
          if ($urandom_range(0, 3) == 0) sv = 5'd0;
          sd[5*u +: 5] = sv;
          if (r[u] && sv != 5'd0) any = 1'b1;
        end
      end while (!any);
      model_pick(r, sd, win);
      run_frame(r, sd, BPF'($urandom), win, m_err, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cdma_spread_sched.md
Name: cdma_spread_sched

Overview:
- Round-robin scheduler that shares one Gold-code spreader (two 5-bit LFSRs, seed load on active-low set, XOR spreading) among NUM_USERS requesters.
- Per frame: grants one user, loads that user's seed into the spreader, then streams BITS_PER_FRAME data bits, each held for CHIPS_PER_BIT chips.
- Inserts a guard gap between frames before re-arbitrating.
- Sits between user-side bit sources and the spreader's set/seed/signal inputs.

Parameters:
NUM_USERS, 4, number of requesters (2..8)
CHIPS_PER_BIT, 31, chips per data bit (one Gold period), >=2
BITS_PER_FRAME, 8, data bits per granted frame, >=1
GUARD_CYCLES, 2, idle cycles between frames, >=1

Ports:
clk_i  in  1  clock
set_i  in  1  asynchronous active-low reset
req_i  in  NUM_USERS  per-user frame request (level)
seed_table_i  in  5*NUM_USERS  user u seed at [5u+4:5u]
data_i  in  NUM_USERS  per-user current data bit
grant_o  out  NUM_USERS  one-hot grant, held for whole frame
bit_ack_o  out  1  one-cycle pulse: granted user's data bit consumed
frame_done_o  out  1  one-cycle pulse on last chip of completed frame
abort_o  out  1  one-cycle pulse when frame aborted
seed_err_o  out  1  sticky: a requester with all-zero seed was skipped
spr_set_no  out  1  to spreader set (active-low seed load)
spr_seed_o  out  5  to spreader seed
spr_signal_o  out  1  to spreader data input

Behaviour:
- All outputs registered. Reset: state IDLE, grant_o=0, bit_ack_o=0, frame_done_o=0, abort_o=0, seed_err_o=0, spr_set_no=0, spr_seed_o=5'b00001, spr_signal_o=0, rr pointer=0.
- States: IDLE, LOAD, SPREAD, GUARD.
- Eligible user: req_i[u]=1 and seed nonzero.
- Requesting users with a zero seed are never granted. seed_err_o sets when one is passed over; cleared only by reset.
- Round-robin: search from pointer upward with wrap-around; the first eligible user wins. On grant, pointer <= winner+1 mod NUM_USERS.
- IDLE:
  - spr_set_no=0.
  - If any user is eligible: -> LOAD, grant_o=winner, spr_seed_o=winner seed.
  - Otherwise remain in IDLE.
- LOAD (exactly 1 cycle):
  - spr_set_no=0 with seed stable, so the spreader loads.
  - Latch data_i[winner] into spr_signal_o; pulse bit_ack_o.
  - -> SPREAD.
- SPREAD:
  - spr_set_no=1. Chip counter runs 0..CHIPS_PER_BIT-1; bit counter runs 0..BITS_PER_FRAME-1.
  - On chip CHIPS_PER_BIT-1 of a non-last bit: latch the next data_i bit and pulse bit_ack_o. The new bit is valid on the following cycle.
  - On the last chip of the last bit: pulse frame_done_o, -> GUARD.
  - Frame length = BITS_PER_FRAME*CHIPS_PER_BIT SPREAD cycles.
- GUARD:
  - spr_set_no=0, spr_signal_o=0, grant_o=0.
  - Lasts GUARD_CYCLES cycles, then -> IDLE, which arbitrates on the next cycle.
- Abort: if req_i of the granted user drops during LOAD or SPREAD:
  - Next cycle: abort_o pulses, -> GUARD.
  - No frame_done_o, no further bit_ack_o.
- A frame in progress is never preempted by other requests.
- Reset mid-frame: immediate return to the reset values above. Pointer returns to 0.
- seed_table_i and data_i are sampled only at the listed points. Changes at other times have no effect.

Optional Feature:
CDMA_PREAMBLE_EN:
- Defined: each frame begins with one preamble bit of value 1 for CHIPS_PER_BIT chips. LOAD latches 1 instead of user data and does not pulse bit_ack_o; the first user bit is latched at the end of the preamble. Frame = (BITS_PER_FRAME+1)*CHIPS_PER_BIT SPREAD cycles.
- Undefined: no preamble, behaviour as above.

Test Plan:
- Reset, no req -> state IDLE, spr_set_no=0, spr_seed_o=5'b00001, all pulses 0 for 50 cycles.
- req_i=4'b0001, seed0=5'b10101, data bits 1,0,1,1,0,0,1,0 -> LOAD 1 cycle after req with spr_seed_o=10101, spr_set_no=0. Then 248 cycles spr_set_no=1. Exactly 8 bit_ack_o pulses, spaced 31 cycles apart. spr_signal_o follows the bit pattern. frame_done_o on the 248th SPREAD cycle. GUARD lasts 2 cycles.
- req_i=4'b1111 held, all seeds nonzero -> grants in order 0,1,2,3,0, each separated by exactly 2 guard cycles plus 1 IDLE cycle.
- req_i=4'b0110, seed1=0 -> user 2 only granted, seed_err_o=1 and stays 1 after req drops.
- Granted user drops req at SPREAD chip 40 -> abort_o pulse next cycle, no frame_done_o, GUARD follows. set_i low mid-frame -> all outputs at reset values immediately.
- With CDMA_PREAMBLE_EN: first 31 SPREAD chips have spr_signal_o=1 with no bit_ack_o in LOAD. Frame is 279 cycles; 8 bit_ack_o pulses.
